fifo_ptr_ctrl: RTL
==================

Name: fifo_ptr_ctrl

Overview:
- Parametrised read/write pointer controller for the lab FIFO. It supersedes the single read-pointer register.
- Holds the write pointer (WP) and read pointer (RP), each with an extra wrap bit.
- Produces full, empty, occupancy count and sticky error flags.
- Supports a read-pointer load so the packet processor can rewind RP to a saved packet start. Sits between the FIFO dual-port memory address inputs and the producer/consumer control logic.

Parameters:
- ADDR_W, 8, pointer address width; DEPTH = 2**ADDR_W entries (power of two only).
- CNT_W, ADDR_W+1, occupancy counter width (derived; do not override).
- AF_THRESH, 2**ADDR_W-2, almost_full asserts when count >= AF_THRESH (ALMOST_FLAGS_EN only).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (ALMOST_FLAGS_EN only).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately; release is sampled on clk).
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- RP_load  in  1  load RP from RP_next this cycle.
- RP_next  in  ADDR_W+1  new RP value including wrap bit (MSB).
- clr_err  in  1  clears sticky error flags.
- WP  out  ADDR_W  write address to memory.
- RP  out  ADDR_W  read address to memory.
- RP_full  out  ADDR_W+1  RP including wrap bit, for the consumer to save as a rewind point.
- wr_ok  out  1  write accepted this cycle.
- rd_ok  out  1  read accepted this cycle.
- full  out  1  DEPTH entries held.
- empty  out  1  0 entries held.
- count  out  CNT_W  occupancy, 0..DEPTH.
- ovf  out  1  sticky overflow: write attempted while full.
- udf  out  1  sticky underflow: read attempted while empty.
- load_err  out  1  sticky: illegal RP_load rejected.

Behaviour:
- Internal state: wp, rp, each ADDR_W+1 bits (MSB is the wrap bit); ovf, udf, load_err registers.
- Reset (rst=0, async): wp=0, rp=0, ovf=udf=load_err=0. Outputs follow: WP=0, RP=0, count=0, empty=1, full=0, wr_ok=rd_ok=0.
- empty = (wp == rp).
- full = (wp[MSB] != rp[MSB]) and the low ADDR_W bits are equal.
- count = wp - rp, modulo 2**(ADDR_W+1).
- Flags and count are combinational decodes of the registered pointers, so they are valid in the same cycle as the pointers.
- wr_ok = wr_en & ~full. rd_ok = rd_en & ~empty & ~RP_load. Both are combinational. Pointers update on the next rising edge.
- Accepted write: wp <= wp+1. Accepted read: rp <= rp+1. Both wrap naturally modulo 2**(ADDR_W+1).
- Simultaneous write and read:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Full: the read is accepted and the write is rejected (ovf sets).
  - Empty: the write is accepted and the read is rejected (udf sets).
- RP_load has priority over rd_en and is legal only when (wp - RP_next) mod 2**(ADDR_W+1) <= DEPTH.
  - Legal load: rp <= RP_next on the next edge, and any rd_en that cycle is ignored (no udf).
  - Illegal load: rp is unchanged and load_err sets.
  - wr_en is processed normally in the same cycle. The legality check uses the current wp, not the incremented one.
- Sticky flags:
  - ovf sets on wr_en & full; udf sets on rd_en & empty & ~RP_load; load_err sets on an illegal load.
  - All three clear on clr_err.
  - If set and clear coincide in the same cycle, set wins.
- Reset mid-operation: all state is cleared immediately, and any in-flight request is discarded.

Optional Feature:
- Macro: FIFO_PTR_ALMOST_FLAGS_EN.
- Defined: adds ports almost_full and almost_empty, each out, 1 bit.
  - almost_full = (count >= AF_THRESH); almost_empty = (count <= AE_THRESH).
  - Both are combinational from the registered pointers. At reset, almost_full=0 and almost_empty=1.
- Undefined: neither port nor its logic exists. AF_THRESH and AE_THRESH are accepted and ignored.

Decomposition:
- Shared package fifo_ptr_pkg: pointer-width function from ADDR_W, and a constant for the reset pointer value 0.
- One natural sub-module: ptr_reg. It is a generic ADDR_W+1 register with async active-low reset, increment enable, load enable and load value. It is instantiated twice (WP without load, RP with load), so RP_Reg functionality is subsumed by it.

Test Plan (ADDR_W=3, DEPTH=8):
- Reset, then 8 writes with no reads: count steps 1..8, WP wraps to 0, wp MSB=1, full=1 after the 8th write. A 9th write gives wr_ok=0, ovf=1, and WP stays 0.
- From full, 8 reads: RP runs 0..7 then wraps to 0, empty=1. A 9th read gives rd_ok=0, udf=1. Pulsing clr_err then clears ovf and udf.
- With count=4, wr_en=rd_en=1 for 10 cycles: count stays 4 and both pointers advance by 10 modulo 16. Also, when full, simultaneous read and write gives count 8->7. When empty, simultaneous read and write gives count 0->1 with udf=1.
- Save RP_full=2, read 3 entries, then RP_load with RP_next=2 while rd_en=1: RP=2, count rises by 3, udf unchanged. Then RP_load with RP_next = wp+1: rejected, load_err=1, RP unchanged.
- Assert rst=0 asynchronously between clock edges at count=5: all outputs reach reset values immediately. After rst=1, the first write on the next edge gives count=1.
- With FIFO_PTR_ALMOST_FLAGS_EN defined (AF=6, AE=2): almost_empty=1 for count 0..2, and almost_full=1 for count 6..8.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// Shared definitions for the FIFO pointer controller: pointer width helper,
// reset pointer value and the sticky error flag bundle.
package fifo_ptr_pkg;

    localparam int PTR_RST_VAL = 0;

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    typedef struct packed {
        logic ovf;
        logic udf;
        logic load_err;
    } err_flags_t;

endpackage

// File: rtl/fifo_ptr_ctrl_ptr_reg.sv
// Generic wrap-bit pointer register with increment and load; load wins when
// both are requested. Asynchronous active-low reset to PTR_RST_VAL.
module ptr_reg
    import fifo_ptr_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_en,
    input  logic         ld_en,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (ld_en) begin
            ptr_d = ld_val;
        end else if (inc_en) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= W'(PTR_RST_VAL);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer controller for the lab FIFO with full/empty/count decode,
// sticky error flags and RP rewind. FIFO_PTR_ALMOST_FLAGS_EN adds almost flags.
module fifo_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = ADDR_W + 1,
    parameter int AF_THRESH = 2**ADDR_W - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              RP_load,
    input  logic [ADDR_W:0]   RP_next,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] WP,
    output logic [ADDR_W-1:0] RP,
    output logic [ADDR_W:0]   RP_full,
    output logic              wr_ok,
    output logic              rd_ok,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              udf,
    output logic              load_err
`ifdef FIFO_PTR_ALMOST_FLAGS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int PTR_W = ptr_width(ADDR_W);
    localparam logic [PTR_W-1:0] DEPTH_PTR = {1'b1, {ADDR_W{1'b0}}};

    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [ADDR_W-1:0] addr_eq;
    logic [PTR_W-1:0]  load_dist;
    logic              load_legal;
    logic              rp_ld;
    err_flags_t        err_q;
    err_flags_t        err_d;

    ptr_reg #(.W(PTR_W)) u_wp (
        .clk    (clk),
        .rst    (rst),
        .inc_en (wr_ok),
        .ld_en  (1'b0),
        .ld_val ({PTR_W{1'b0}}),
        .ptr    (wp)
    );

    ptr_reg #(.W(PTR_W)) u_rp (
        .clk    (clk),
        .rst    (rst),
        .inc_en (rd_ok),
        .ld_en  (rp_ld),
        .ld_val (RP_next),
        .ptr    (rp)
    );

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_addr_eq
            assign addr_eq[gi] = ~(wp[gi] ^ rp[gi]);
        end
    endgenerate

    assign empty = (wp == rp);
    assign full  = (wp[ADDR_W] != rp[ADDR_W]) && (&addr_eq);
    assign count = CNT_W'(wp - rp);

    // Requests are gated by reset so nothing looks accepted while it is held.
    assign wr_ok = rst & wr_en & ~full;
    assign rd_ok = rst & rd_en & ~empty & ~RP_load;

    // Rewind target must leave no more than DEPTH entries between it and wp.
    assign load_dist  = wp - RP_next;
    assign load_legal = (load_dist <= DEPTH_PTR);
    assign rp_ld      = rst & RP_load & load_legal;

    always_comb begin
        err_d.ovf      = (wr_en & full) | (err_q.ovf & ~clr_err);
        err_d.udf      = (rd_en & empty & ~RP_load) | (err_q.udf & ~clr_err);
        err_d.load_err = (RP_load & ~load_legal) | (err_q.load_err & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ovf      = err_q.ovf;
    assign udf      = err_q.udf;
    assign load_err = err_q.load_err;

    assign WP      = wp[ADDR_W-1:0];
    assign RP      = rp[ADDR_W-1:0];
    assign RP_full = rp;

`ifdef FIFO_PTR_ALMOST_FLAGS_EN
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));
`else
    localparam logic unused_thresh = (AF_THRESH != AE_THRESH);
`endif

endmodule
